// File: rtl/gps_axi_lite_arbiter.sv
// Two-requester arbiter serialising single-beat AXI4-Lite reads/writes onto one master port.
// Define GPS_ARB_FIXED_PRIO_EN to make requester 0 win every tie (no round-robin state).
module gps_axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_write,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0] req_wstrb,
    output logic [1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic [ADDR_WIDTH-1:0]       M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]       M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]       M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]       M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
`ifndef GPS_ARB_FIXED_PRIO_EN
    logic                    last_grant_q, last_grant_d;
`endif

    logic pick;
    logic aw_done;
    logic w_done;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
`ifndef GPS_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        req_ready = '0;
        pick      = 1'b0;
        aw_done   = 1'b0;
        w_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    if (req_valid == 2'b11) begin
`ifdef GPS_ARB_FIXED_PRIO_EN
                        pick = 1'b0;
`else
                        pick = ~last_grant_q;
`endif
                    end else begin
                        pick = req_valid[1];
                    end
                    req_ready = pick ? 2'b10 : 2'b01;
                    gnt_d     = pick;
                    addr_d    = pick ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
                    wdata_d   = pick ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
                    wstrb_d   = pick ? req_wstrb[STRB_WIDTH +: STRB_WIDTH] : req_wstrb[0 +: STRB_WIDTH];
                    rdata_d   = '0;
                    resp_d    = '0;
                    if (pick ? req_write[1] : req_write[0]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                // A channel already handshaken has its valid low, so it counts as done.
                aw_done = !awvalid_q || M_AXI_AWREADY;
                w_done  = !wvalid_q  || M_AXI_WREADY;
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done)          state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = DONE;
                end
            end
            DONE: begin
`ifndef GPS_ARB_FIXED_PRIO_EN
                last_grant_d = gnt_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ARESET) req_ready = '0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
`ifndef GPS_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
`ifndef GPS_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign rsp_valid     = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == RD_DATA);

endmodule

// File: tb/tb_gps_axi_lite_arbiter.sv
// Scoreboard bench for gps_axi_lite_arbiter with a behavioural AXI4-Lite slave.
// Honours GPS_ARB_FIXED_PRIO_EN when choosing the expected grant order.
module tb_gps_axi_lite_arbiter;

    localparam logic [31:0] BASE = 32'h4000_0000;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [7:0]  lat;
        logic [7:0]  awc;
        logic [7:0]  wc;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  rsp_valid, rsp_resp;
    logic [31:0] rsp_rdata;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic M_AXI_RVALID, M_AXI_RREADY;

    gps_axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Scoreboard queues: filled by the stimulus, drained by the monitor.
    exp_t q0[$];
    exp_t q1[$];
    int   gq[$];
    int   timeouts = 0;
    logic done_req = 1'b0;

    // Slave knobs, owned by the stimulus process.
    int         aw_delay = 0;
    int         w_delay  = 0;
    int         b_delay  = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [1:0] rresp_cfg = 2'b00;

    // Behavioural slave: ready/valid decisions made on the falling edge.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_word;
    logic [3:0]  s_wstrb;
    logic        aw_got, w_got, ar_got, b_fire, r_fire;
    int          aw_cnt, w_cnt, b_cnt;

    always @(negedge ACLK) begin
        if (ARESET) begin
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
            M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
            M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
            aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_fire = 1'b0; r_fire = 1'b0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (M_AXI_AWREADY) begin
                M_AXI_AWREADY = 1'b0; aw_got = 1'b1;
            end else if (M_AXI_AWVALID && !aw_got) begin
                if (aw_cnt == aw_delay) begin
                    M_AXI_AWREADY = 1'b1; s_awaddr = M_AXI_AWADDR; aw_cnt = 0;
                end else aw_cnt++;
            end
            if (M_AXI_WREADY) begin
                M_AXI_WREADY = 1'b0; w_got = 1'b1;
            end else if (M_AXI_WVALID && !w_got) begin
                if (w_cnt == w_delay) begin
                    M_AXI_WREADY = 1'b1; s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB; w_cnt = 0;
                end else w_cnt++;
            end
            if (b_fire) begin M_AXI_BVALID = 1'b0; b_fire = 1'b0; end
            if (!M_AXI_BVALID && aw_got && w_got) begin
                if (b_cnt == b_delay) begin
                    s_word = mem.exists(s_awaddr) ? mem[s_awaddr] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) s_word[b*8 +: 8] = s_wdata[b*8 +: 8];
                    mem[s_awaddr] = s_word;
                    M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp_cfg;
                    aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
                end else b_cnt++;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_fire = 1'b1;
            if (M_AXI_ARREADY) begin
                M_AXI_ARREADY = 1'b0; ar_got = 1'b1;
            end else if (M_AXI_ARVALID && !ar_got) begin
                M_AXI_ARREADY = 1'b1; s_araddr = M_AXI_ARADDR;
            end
            if (r_fire) begin M_AXI_RVALID = 1'b0; r_fire = 1'b0; end
            if (!M_AXI_RVALID && ar_got) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = mem.exists(s_araddr) ? mem[s_araddr] : 32'h0;
                M_AXI_RRESP  = rresp_cfg;
                ar_got = 1'b0;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) r_fire = 1'b1;
        end
    end

    // Monitor: sole owner of the comparison counters.
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   gcyc0 = 0, gcyc1 = 0;
    int   awhi = 0, whi = 0, g, r;
    logic aw_ok = 1'b0, w_ok = 1'b0, rst_seen = 1'b0;
    exp_t e, a;

    always begin
        @(negedge ACLK);
        #1;
        cyc++;
        if (cyc > 20000) begin
            mismatched++;
            $display("FAIL watchdog: got cycle %0d required <= 20000", cyc);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $fatal(1, "watchdog expired");
        end
        if (ARESET) begin
            q0.delete(); q1.delete(); gq.delete();
            rst_seen = 1'b1; aw_ok = 1'b0; w_ok = 1'b0;
        end else begin
            if (rst_seen) begin
                compared++;
                if ({req_ready, rsp_valid, rsp_rdata, rsp_resp, M_AXI_AWVALID, M_AXI_WVALID,
                     M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} != '0) begin
                    mismatched++;
                    $display("FAIL reset_outputs: got rdy=%b rspv=%b rdata=%h resp=%b aw=%b w=%b b=%b ar=%b r=%b required all 0",
                             req_ready, rsp_valid, rsp_rdata, rsp_resp, M_AXI_AWVALID, M_AXI_WVALID,
                             M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY);
                end
                rst_seen = 1'b0;
            end
            if (req_ready != 2'b00) begin
                compared++;
                if (gq.size() == 0) begin
                    mismatched++;
                    $display("FAIL grant: got req_ready=%b required no grant", req_ready);
                end else begin
                    g = gq.pop_front();
                    if (req_ready != (2'b01 << g)) begin
                        mismatched++;
                        $display("FAIL grant: got req_ready=%b required %b", req_ready, 2'b01 << g);
                    end
                end
                if (req_ready[0]) gcyc0 = cyc;
                if (req_ready[1]) gcyc1 = cyc;
                awhi = 0; whi = 0; aw_ok = 1'b0; w_ok = 1'b0;
            end
            if (M_AXI_BREADY) begin
                compared++;
                if (!(aw_ok && w_ok)) begin
                    mismatched++;
                    $display("FAIL bready_early: got aw_done=%b w_done=%b required 1 1", aw_ok, w_ok);
                end
            end
            if (M_AXI_AWVALID) awhi++;
            if (M_AXI_WVALID)  whi++;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_ok = 1'b1;
                compared++;
                if (M_AXI_AWPROT != 3'b000) begin
                    mismatched++;
                    $display("FAIL awprot: got %b required 000", M_AXI_AWPROT);
                end
            end
            if (M_AXI_WVALID && M_AXI_WREADY) w_ok = 1'b1;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                compared++;
                if (M_AXI_ARPROT != 3'b000) begin
                    mismatched++;
                    $display("FAIL arprot: got %b required 000", M_AXI_ARPROT);
                end
            end
            if (rsp_valid != 2'b00) begin
                compared++;
                r = rsp_valid[1] ? 1 : 0;
                if (rsp_valid == 2'b11 || (r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
                    mismatched++;
                    $display("FAIL response: got rsp_valid=%b required no response", rsp_valid);
                end else begin
                    e = (r == 1) ? q1.pop_front() : q0.pop_front();
                    a.rdata = rsp_rdata;
                    a.resp  = rsp_resp;
                    a.lat   = 8'(cyc - ((r == 1) ? gcyc1 : gcyc0));
                    a.awc   = 8'(awhi);
                    a.wc    = 8'(whi);
                    if (a != e) begin
                        mismatched++;
                        $display("FAIL response_r%0d: got rdata=%h resp=%b lat=%0d awv=%0d wv=%0d required rdata=%h resp=%b lat=%0d awv=%0d wv=%0d",
                                 r, a.rdata, a.resp, a.lat, a.awc, a.wc, e.rdata, e.resp, e.lat, e.awc, e.wc);
                    end
                end
            end
        end
        if (done_req) begin
            compared++;
            if (q0.size() + q1.size() + gq.size() != 0) begin
                mismatched++;
                $display("FAIL drain: got %0d outstanding expectations required 0", q0.size() + q1.size() + gq.size());
            end
            compared++;
            if (timeouts != 0) begin
                mismatched++;
                $display("FAIL handshake_timeout: got %0d timeouts required 0", timeouts);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    function automatic exp_t mk(input logic [31:0] d, input logic [1:0] rs, input int lat,
                                input int awc, input int wc);
        exp_t x;
        x.rdata = d; x.resp = rs; x.lat = 8'(lat); x.awc = 8'(awc); x.wc = 8'(wc);
        return x;
    endfunction

    // Presents one request on requester r and holds it until granted; returns at posedge+1.
    task automatic drive(input int r, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st);
        int n;
        req_write[r]        = wr;
        req_addr[r*32 +: 32] = addr;
        req_wdata[r*32 +: 32] = wd;
        req_wstrb[r*4 +: 4] = st;
        req_valid[r]        = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!req_ready[r] && n < 200);
        if (n >= 200) timeouts++;
        @(posedge ACLK);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + gq.size()) != 0 && n < 500) begin
            @(posedge ACLK);
            n++;
        end
        if (n >= 500) timeouts++;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge ACLK); #1; ARESET = 1'b1;
        @(posedge ACLK); #1; ARESET = 1'b0;
        @(posedge ACLK); #1;
    endtask

    initial begin
        int n;
        ARESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(posedge ACLK); #1;

        // r0 write then read-back with a zero-wait slave
        gq.push_back(0); q0.push_back(mk(32'h0, 2'b00, 3, 1, 1));
        drive(0, 1'b1, BASE, 32'h0101FFFF, 4'hF);
        gq.push_back(0); q0.push_back(mk(32'h0101FFFF, 2'b00, 3, 0, 0));
        drive(0, 1'b0, BASE, 32'h0, 4'h0);
        wait_idle();

        // simultaneous requests straight after reset: r0 wins the first tie
        do_reset();
        gq.push_back(0); gq.push_back(1);
        q0.push_back(mk(32'h0, 2'b00, 3, 1, 1));
        q1.push_back(mk(32'hABCD0001, 2'b00, 3, 0, 0));
        fork
            drive(0, 1'b1, BASE + 32'h4, 32'hABCD0001, 4'hF);
            drive(1, 1'b0, BASE + 32'h4, 32'h0, 4'h0);
        join
        wait_idle();

        // both requesters continuously valid for eight transactions
`ifdef GPS_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) gq.push_back(0);
        for (int k = 0; k < 4; k++) gq.push_back(1);
`else
        for (int k = 0; k < 4; k++) begin gq.push_back(0); gq.push_back(1); end
`endif
        for (int k = 0; k < 4; k++) begin
            q0.push_back(mk(32'h0, 2'b00, 3, 1, 1));
            q1.push_back(mk(32'hABCD0001, 2'b00, 3, 0, 0));
        end
        fork
            begin
                for (int k = 0; k < 4; k++)
                    drive(0, 1'b1, BASE + 32'h20 + 32'(4*k), 32'h1000_0000 + 32'(k), 4'hF);
            end
            begin
                for (int k = 0; k < 4; k++)
                    drive(1, 1'b0, BASE + 32'h4, 32'h0, 4'h0);
            end
        join
        wait_idle();

        // AWREADY held off three cycles, WREADY immediate
        aw_delay = 3;
        gq.push_back(0); q0.push_back(mk(32'h0, 2'b00, 6, 4, 1));
        drive(0, 1'b1, BASE + 32'h8, 32'h5555AAAA, 4'hF);
        wait_idle();
        aw_delay = 0;
        gq.push_back(0); q0.push_back(mk(32'h5555AAAA, 2'b00, 3, 0, 0));
        drive(0, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
        wait_idle();

        // error responses pass through, then a clean transaction with partial strobes
        bresp_cfg = 2'b10;
        gq.push_back(1); q1.push_back(mk(32'h0, 2'b10, 3, 1, 1));
        drive(1, 1'b1, BASE + 32'hC, 32'h12345678, 4'hF);
        wait_idle();
        bresp_cfg = 2'b00; rresp_cfg = 2'b11;
        gq.push_back(0); q0.push_back(mk(32'h12345678, 2'b11, 3, 0, 0));
        drive(0, 1'b0, BASE + 32'hC, 32'h0, 4'h0);
        wait_idle();
        rresp_cfg = 2'b00;
        gq.push_back(1); q1.push_back(mk(32'h0, 2'b00, 3, 1, 1));
        drive(1, 1'b1, BASE + 32'hC, 32'hFFFFFFFF, 4'b0011);
        gq.push_back(1); q1.push_back(mk(32'h1234FFFF, 2'b00, 3, 0, 0));
        drive(1, 1'b0, BASE + 32'hC, 32'h0, 4'h0);
        wait_idle();

        // reset while waiting for B: the in-flight write must never respond
        b_delay = 4;
        gq.push_back(0); q0.push_back(mk(32'h0, 2'b00, 3, 1, 1));
        drive(0, 1'b1, BASE + 32'h10, 32'h0BADC0DE, 4'hF);
        n = 0;
        while (!M_AXI_BREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 50) timeouts++;
        do_reset();
        b_delay = 0;
        gq.push_back(1); q1.push_back(mk(32'h0, 2'b00, 3, 1, 1));
        drive(1, 1'b1, BASE + 32'h14, 32'hC0FFEE01, 4'hF);
        gq.push_back(1); q1.push_back(mk(32'hC0FFEE01, 2'b00, 3, 0, 0));
        drive(1, 1'b0, BASE + 32'h14, 32'h0, 4'h0);
        wait_idle();
        repeat (4) @(posedge ACLK);
        #1 done_req = 1'b1;
    end

endmodule
